// File: rtl/usb_rx_packet_buffer.sv
// Speculative RX byte buffer: DATA-packet bytes commit on clean end, roll back on error.
// Optional CRC16 trailer removal at commit is enabled by defining USB_RX_CRC_STRIP_EN.
module usb_rx_packet_buffer #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8,
    parameter int PKT_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PKT_WIDTH-1:0]    RX_packet,
    input  logic                    store_RX_packet_data,
    input  logic [DATA_WIDTH-1:0]   RX_packet_data,
    input  logic                    get_RX_data,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   RX_data,
    output logic [$clog2(DEPTH):0]  buffer_occupancy,
    output logic                    packet_done,
    output logic                    packet_bad,
    output logic                    overflow,
    output logic [1:0]              dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PKT_WIDTH-1:0] PKT_IDLE = PKT_WIDTH'(0);
    localparam logic [PKT_WIDTH-1:0] PKT_DATA = PKT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DISCARD = 2'd2} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [PW-1:0]         r_rptr, r_cwptr, r_swptr;
    logic                  r_tainted, r_overflow, r_done, r_bad;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0] w_occ, w_spec, w_commit_ptr;
    logic          w_is_data, w_is_idle, w_len_ok;
    logic          w_write, w_drop, w_commit, w_rollback, w_pop;

    assign w_occ     = r_cwptr - r_rptr;
    assign w_spec    = r_swptr - r_rptr;
    assign w_is_data = (RX_packet == PKT_DATA);
    assign w_is_idle = (RX_packet == PKT_IDLE);
    // Reads are not a handshake: a pop on an empty buffer is simply dropped.
    assign w_pop     = get_RX_data && (w_occ != '0);

`ifdef USB_RX_CRC_STRIP_EN
    logic [PW-1:0] w_pkt_len;
    assign w_pkt_len    = r_swptr - r_cwptr;
    assign w_len_ok     = (w_pkt_len >= PW'(2));
    assign w_commit_ptr = r_swptr - PW'(2);
`else
    assign w_len_ok     = 1'b1;
    assign w_commit_ptr = r_swptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            if (r_state == S_COLLECT) w_next_state = S_DISCARD;
        end else begin
            case (r_state)
                S_IDLE:    if (w_is_data)  w_next_state = S_COLLECT;
                S_COLLECT: if (!w_is_data) w_next_state = S_IDLE;
                S_DISCARD: if (w_is_idle)  w_next_state = S_IDLE;
                default:                   w_next_state = S_IDLE;
            endcase
        end
    end

    // Datapath decode; any non-DATA code ends the packet, only a clean IDLE commits.
    always_comb begin
        w_write    = 1'b0;
        w_drop     = 1'b0;
        w_commit   = 1'b0;
        w_rollback = 1'b0;
        if (!flush && r_state == S_COLLECT) begin
            if (w_is_data) begin
                if (store_RX_packet_data) begin
                    if (w_spec < DEPTH_P) w_write = 1'b1;
                    else                  w_drop  = 1'b1;
                end
            end else if (w_is_idle && !r_tainted && w_len_ok) begin
                w_commit = 1'b1;
            end else begin
                w_rollback = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr     <= '0;
            r_cwptr    <= '0;
            r_swptr    <= '0;
            r_tainted  <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_bad  <= w_rollback;
            if (flush) begin
                r_rptr     <= '0;
                r_cwptr    <= '0;
                r_swptr    <= '0;
                r_tainted  <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_pop)   r_rptr <= r_rptr + PW'(1);
                if (w_write) r_swptr <= r_swptr + PW'(1);
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    r_tainted  <= 1'b1;
                end
                // Speculative pointer follows the commit so stripped CRC bytes get reused.
                if (w_commit) begin
                    r_cwptr <= w_commit_ptr;
                    r_swptr <= w_commit_ptr;
                end
                if (w_rollback) r_swptr <= r_cwptr;
                if (r_state == S_IDLE && w_is_data) r_tainted <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_swptr[AW-1:0]] <= RX_packet_data;
    end

    assign RX_data          = r_mem[r_rptr[AW-1:0]];
    assign buffer_occupancy = w_occ;
    assign packet_done      = r_done;
    assign packet_bad       = r_bad;
    assign overflow         = r_overflow;
    assign dbg_state        = r_state;
endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// Bench for usb_rx_packet_buffer: packet-level queue model of committed bytes.
module tb_usb_rx_packet_buffer;
  localparam int DEPTH = 64;
  localparam logic [2:0] P_IDLE = 3'd0, P_DATA = 3'd1, P_OUT = 3'd2, P_ACK = 3'd4, P_BAD = 3'd6;
`ifdef USB_RX_CRC_STRIP_EN
  localparam int CRC_LEN = 2;
`else
  localparam int CRC_LEN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] RX_packet = P_IDLE;
  logic       store_RX_packet_data = 1'b0;
  logic [7:0] RX_packet_data = 8'h00;
  logic       get_RX_data = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] RX_data;
  logic [6:0] buffer_occupancy;
  logic       packet_done, packet_bad, overflow;
  logic [1:0] dbg_state;

  usb_rx_packet_buffer dut (
    .clk(clk), .rst(rst), .RX_packet(RX_packet),
    .store_RX_packet_data(store_RX_packet_data), .RX_packet_data(RX_packet_data),
    .get_RX_data(get_RX_data), .flush(flush), .RX_data(RX_data),
    .buffer_occupancy(buffer_occupancy), .packet_done(packet_done),
    .packet_bad(packet_bad), .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  bit         exp_ovf = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic send_packet(input logic [2:0] end_code, input bit pop_at_end);
    logic [7:0] pend[$];
    bit dropped;
    bit ok;
    bit popped;
    dropped = 1'b0;
    RX_packet = P_DATA;
    step();
    for (int i = 0; i < stim_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) step();
      store_RX_packet_data = 1'b1;
      RX_packet_data = stim_q[i];
      step();
      store_RX_packet_data = 1'b0;
      if (exp_q.size() + pend.size() < DEPTH) pend.push_back(stim_q[i]);
      else begin
        dropped = 1'b1;
        exp_ovf = 1'b1;
      end
      check("ovf_in_pkt", 32'(overflow), 32'(exp_ovf));
      check("occ_in_pkt", 32'(buffer_occupancy), 32'(exp_q.size()));
    end
    popped = pop_at_end && (exp_q.size() > 0);
    if (popped) begin
      check("rx_data_end", 32'(RX_data), 32'(exp_q[0]));
      get_RX_data = 1'b1;
    end
    RX_packet = end_code;
    step();
    get_RX_data = 1'b0;
    RX_packet = P_IDLE;
    if (popped) void'(exp_q.pop_front());
    ok = (end_code == P_IDLE) && !dropped && (pend.size() >= CRC_LEN);
    if (ok) for (int i = 0; i < pend.size() - CRC_LEN; i++) exp_q.push_back(pend[i]);
    check("packet_done", 32'(packet_done), 32'(ok));
    check("packet_bad", 32'(packet_bad), 32'(!ok));
    check("occ_after_end", 32'(buffer_occupancy), 32'(exp_q.size()));
    check("ovf_after_end", 32'(overflow), 32'(exp_ovf));
    step();
    check("done_one_cycle", 32'(packet_done), 32'd0);
    check("bad_one_cycle", 32'(packet_bad), 32'd0);
  endtask

  task automatic pop_n(input int k);
    for (int i = 0; i < k; i++) begin
      if (exp_q.size() == 0) begin
        get_RX_data = 1'b1;
        step();
        get_RX_data = 1'b0;
        check("occ_empty_pop", 32'(buffer_occupancy), 32'd0);
      end else begin
        check("rx_data", 32'(RX_data), 32'(exp_q[0]));
        get_RX_data = 1'b1;
        step();
        get_RX_data = 1'b0;
        void'(exp_q.pop_front());
        check("occ_pop", 32'(buffer_occupancy), 32'(exp_q.size()));
      end
      if ($urandom_range(0, 2) == 0) step();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    check("occ_flush", 32'(buffer_occupancy), 32'd0);
    check("ovf_flush", 32'(overflow), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    repeat (3) step();
    rst = 1'b0;
    check("rst_occ", 32'(buffer_occupancy), 32'd0);
    check("rst_done", 32'(packet_done), 32'd0);
    check("rst_bad", 32'(packet_bad), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // clean DATA packet, in-order pops
    stim_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_packet(P_IDLE, 1'b0);
    check("t1_occ", 32'(buffer_occupancy), 32'(4 - CRC_LEN));
    check("t1_head", 32'(RX_data), 32'hA1);
    pop_n(exp_q.size());

    // rollback on BAD, then a fresh packet
    stim_q = '{8'h11, 8'h22};
    send_packet(P_BAD, 1'b0);
    check("t2_occ", 32'(buffer_occupancy), 32'd0);
    fill_random(3 + CRC_LEN);
    send_packet(P_IDLE, 1'b0);
    check("t2_next_head", 32'(RX_data), 32'(exp_q[0]));
    pop_n(exp_q.size());

    // overflow taints the packet and stays sticky until flush
    do_flush();
    fill_random(DEPTH + 1);
    send_packet(P_IDLE, 1'b0);
    check("t3_ovf", 32'(overflow), 32'd1);
    fill_random(2 + CRC_LEN);
    send_packet(P_IDLE, 1'b0);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    pop_n(exp_q.size());
    do_flush();

    // pointer wrap
    fill_random(62);
    send_packet(P_IDLE, 1'b0);
    pop_n(exp_q.size());
    fill_random(10 + CRC_LEN);
    send_packet(P_IDLE, 1'b0);
    check("t4_occ", 32'(buffer_occupancy), 32'd10);
    pop_n(exp_q.size());

    // empty pop is ignored; pop concurrent with commit
    pop_n(2);
    fill_random(2 + CRC_LEN);
    send_packet(P_IDLE, 1'b0);
    check("t5_occ2", 32'(buffer_occupancy), 32'd2);
    fill_random(3 + CRC_LEN);
    send_packet(P_IDLE, 1'b1);
    check("t5_occ4", 32'(buffer_occupancy), 32'd4);
    pop_n(exp_q.size());

    // flush mid-packet: DISCARD ignores strobes, no pulse
    RX_packet = P_DATA;
    step();
    for (int i = 0; i < 5; i++) begin
      store_RX_packet_data = 1'b1;
      RX_packet_data = 8'($urandom);
      step();
    end
    store_RX_packet_data = 1'b0;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      store_RX_packet_data = 1'b1;
      RX_packet_data = 8'($urandom);
      step();
      check("t6_occ", 32'(buffer_occupancy), 32'd0);
      check("t6_no_done", 32'(packet_done), 32'd0);
      check("t6_no_bad", 32'(packet_bad), 32'd0);
    end
    store_RX_packet_data = 1'b0;
    RX_packet = P_IDLE;
    step();
    step();
    check("t6_no_done_end", 32'(packet_done), 32'd0);
    check("t6_no_bad_end", 32'(packet_bad), 32'd0);
    fill_random(4 + CRC_LEN);
    send_packet(P_IDLE, 1'b0);
    check("t6_occ_after", 32'(buffer_occupancy), 32'd4);
    pop_n(exp_q.size());

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [2:0] code;
      case ($urandom_range(0, 5))
        0: code = P_BAD;
        1: code = P_OUT;
        2: code = P_ACK;
        default: code = P_IDLE;
      endcase
      fill_random($urandom_range(0, 24));
      send_packet(code, 1'($urandom_range(0, 1)));
      pop_n($urandom_range(0, 16));
      if ($urandom_range(0, 9) == 0) do_flush();
    end
    pop_n(exp_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
